brent32_sub_pipe: RTL and testbench

- Pipelined 32-bit Brent-Kung subtractor: the inverse arithmetic direction of the brent32 combinational adder.
- Computes diff = a - b - bin. Operand pairs arrive on a valid/ready input channel; results leave on a valid/ready output channel with backpressure.
- Sits in the datapath next to brent32 so that add and subtract share the same prefix-tree structure. The tree is split across two register stages to close timing at higher clock rates.

---
 rtl/brent32_sub_pipe.sv | 131 +++++++++++++
 tb/tb_brent32_sub_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/brent32_sub_pipe.sv
// rtl/brent32_sub_pipe.sv - two-stage pipelined Brent-Kung subtractor, diff = a - b - bin
module brent32_sub_pipe #(
    parameter int WIDTH     = 32,
    parameter int UP_LEVELS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int LOG  = $clog2(WIDTH);
    localparam int NUP2 = LOG - UP_LEVELS;
    localparam int NS2  = NUP2 + LOG - 1;

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_gg;
    logic [WIDTH-1:0] s1_pg;
    logic             s1_c0;

    logic [WIDTH-1:0] pb;
    logic             c0;

    assign s2_adv   = ~s2_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv;

    assign pb = a ^ ~b;
    assign c0 = ~bin;

    // Carry-in is folded into bit 0's generate so every carry comes out of the tree.
    for (genvar l = 0; l <= UP_LEVELS; l++) begin : up1
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        if (l == 0) begin : seed
            assign p = pb;
            assign g = (a & ~b) | {{(WIDTH-1){1'b0}}, pb[0] & c0};
        end else begin : lvl
            for (genvar i = 0; i < WIDTH; i++) begin : gb
                if (((i + 1) % (1 << l)) == 0) begin : node
                    assign g[i] = up1[l-1].g[i] | (up1[l-1].p[i] & up1[l-1].g[i-(1<<(l-1))]);
                    assign p[i] = up1[l-1].p[i] & up1[l-1].p[i-(1<<(l-1))];
                end else begin : pass
                    assign g[i] = up1[l-1].g[i];
                    assign p[i] = up1[l-1].p[i];
                end
            end
        end
    end

    // Stage 2 finishes the up-sweep, then walks the down-sweep from the widest span to span 1.
    for (genvar k = 0; k <= NS2; k++) begin : tree
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        if (k == 0) begin : seed
            assign g = s1_gg;
            assign p = s1_pg;
        end else begin : lvl
            localparam bit IS_UP = (k <= NUP2);
            localparam int L     = IS_UP ? UP_LEVELS + k : LOG - (k - NUP2);
            localparam int H     = 1 << (L - 1);
            for (genvar i = 0; i < WIDTH; i++) begin : gb
                if (IS_UP ? (((i + 1) % (2 * H)) == 0)
                          : ((i >= 3 * H - 1) && (((i + 1) % (2 * H)) == H))) begin : node
                    assign g[i] = tree[k-1].g[i] | (tree[k-1].p[i] & tree[k-1].g[i-H]);
                    assign p[i] = tree[k-1].p[i] & tree[k-1].p[i-H];
                end else begin : pass
                    assign g[i] = tree[k-1].g[i];
                    assign p[i] = tree[k-1].p[i];
                end
            end
        end
    end

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] diff_n;
    logic             unused_grp_p;

    assign carry        = {tree[NS2].g, s1_c0};
    assign diff_n       = s1_p ^ carry[WIDTH-1:0];
    assign unused_grp_p = ^tree[NS2].p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_gg    <= '0;
            s1_pg    <= '0;
            s1_c0    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_p  <= pb;
                s1_gg <= up1[UP_LEVELS].g;
                s1_pg <= up1[UP_LEVELS].p;
                s1_c0 <= c0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
            ovf      <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                diff <= diff_n;
                bout <= ~carry[WIDTH];
                ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
            end
        end
    end

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_brent32_sub_pipe.sv
// tb/tb_brent32_sub_pipe.sv - randomized scoreboard bench for brent32_sub_pipe
module tb_brent32_sub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;

    brent32_sub_pipe #(.WIDTH(32), .UP_LEVELS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          res_cnt = 0;
    logic [33:0] exp_q[$];
    logic [31:0] got_q[$];
    int          got_cyc[$];
    logic        stall_prev = 1'b0;
    logic [34:0] held = '0;

    logic [31:0] ba[4]   = '{32'd5, 32'd10, 32'd7, 32'hFFFF_FFFF};
    logic [31:0] bb[4]   = '{32'd3, 32'd10, 32'd9, 32'hFFFF_FFFF};
    logic        bc[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] bexp[4] = '{32'd2, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF};

    // Returns {bout, ovf, diff} from plain wide arithmetic.
    function automatic logic [33:0] ref_sub(input logic [31:0] x, input logic [31:0] y, input logic c);
        longint ux, uy, sx, sy, ud, sd;
        logic   rb, ro;
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ud = ux - uy - longint'(c);
        sd = sx - sy - longint'(c);
        rb = (ud < 0);
        ro = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        return {rb, ro, ud[31:0]};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [31:0] x, input logic [31:0] y, input logic c,
                            input logic [31:0] ed, input logic eb, input logic eo, input string tag);
        a = x; b = y; bin = c; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; a = $urandom; b = $urandom;
        chk({tag, "_lat1"}, 64'(out_valid), 0);
        tick();
        chk({tag, "_valid"}, 64'(out_valid), 1);
        chk({tag, "_diff"}, 64'(diff), 64'(ed));
        chk({tag, "_bout"}, 64'(bout), 64'(eb));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
    endtask

    // Scoreboard: handshakes are observed on the falling edge, ahead of the rising edge that commits them.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) chk("hold", 64'({out_valid, bout, ovf, diff}), 64'(held));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'(exp_q.size()), 1);
                end else begin
                    chk("result", 64'({bout, ovf, diff}), 64'(exp_q.pop_front()));
                end
                res_cnt++;
                got_q.push_back(diff);
                got_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sub(a, b, bin));
                acc_cnt++;
            end
            stall_prev = out_valid && !out_ready;
            held = {out_valid, bout, ovf, diff};
        end
    end

    initial begin
        int   idx;
        bit   acc;
        int   start_res, start_acc, cycles;
        int   n_rand;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_diff", 64'(diff), 0);
        chk("rst_bout", 64'(bout), 0);
        chk("rst_ovf", 64'(ovf), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        rst_n = 1'b1;
        chk("post_rst_in_ready", 64'(in_ready), 1);
        tick();

        send_one(32'hF19F_001F, 32'h01E6_0EEC, 1'b0, 32'hEFB8_F133, 1'b0, 1'b0, "basic");
        send_one(32'h0, 32'h1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, "wrap_b1");
        send_one(32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, "wrap_bin");
        send_one(32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, "ovf_neg");
        send_one(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, "ovf_pos");
        send_one(32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0, "equal");
        tick();

        got_q.delete();
        got_cyc.delete();
        idx = 0;
        out_ready = 1'b0;
        a = ba[0]; b = bb[0]; bin = bc[0]; in_valid = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 4) begin a = ba[idx]; b = bb[idx]; bin = bc[idx]; end
                else in_valid = 1'b0;
            end
        end
        chk("bp_accepted", 64'(idx), 2);
        chk("bp_in_ready", 64'(in_ready), 0);
        chk("bp_out_valid", 64'(out_valid), 1);
        chk("bp_diff_held", 64'(diff), 2);
        out_ready = 1'b1;
        for (int t = 0; t < 30 && (idx < 4 || got_q.size() < 4); t++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 4) begin a = ba[idx]; b = bb[idx]; bin = bc[idx]; end
                else in_valid = 1'b0;
            end
        end
        chk("bp_count", 64'(got_q.size()), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < got_q.size()) begin
                chk("bp_order", 64'(got_q[k]), 64'(bexp[k]));
                chk("bp_no_gap", 64'(got_cyc[k] - got_cyc[0]), 64'(k));
            end
        end

        out_ready = 1'b0;
        a = 32'd5; b = 32'd3; bin = 1'b0; in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("rst_mid_full_valid", 64'(out_valid), 1);
        chk("rst_mid_full_ready", 64'(in_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 0);
        chk("rst_mid_diff", 64'(diff), 0);
        chk("rst_mid_in_ready", 64'(in_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_no_stale", 64'(out_valid), 0);
        end
        send_one(32'd5, 32'd3, 1'b0, 32'd2, 1'b0, 1'b0, "post_rst");
        tick();

        n_rand = 10000;
        start_res = res_cnt;
        start_acc = acc_cnt;
        cycles = 0;
        while ((acc_cnt - start_acc) < n_rand && cycles < 60000) begin
            a = pick_operand();
            b = pick_operand();
            bin = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            cycles++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick();
        tick();
        chk("rand_drained", 64'(exp_q.size()), 0);
        chk("rand_results", 64'(res_cnt - start_res), 64'(n_rand));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
